// File: rtl/gpio_poll_pkg.sv
// Shared types and constants for the gpio poll master: FSM state encoding,
// default peripheral register addresses and the pin group widths.
package gpio_poll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  localparam logic [3:0] OUT_ADDR_DEF = 4'h0;
  localparam logic [3:0] IN_ADDR_DEF  = 4'h1;

  localparam int GPIO_IN_BITS  = 6;
  localparam int GPIO_OUT_BITS = 4;

endpackage

// File: rtl/gpio_poll_master_if.sv
// Register bus between the poll master and the gpio peripheral.
// M_DATA_IN is combinational read data driven by the peripheral.
interface gpio_poll_master_if #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 4
);
  logic [ADDRESS_BITS-1:0] M_ADDRESS;
  logic [BITS-1:0]         M_DATA_OUT;
  logic [BITS-1:0]         M_DATA_IN;
  logic                    M_WR;

  modport master (
    output M_ADDRESS,
    output M_DATA_OUT,
    output M_WR,
    input  M_DATA_IN
  );

  modport slave (
    input  M_ADDRESS,
    input  M_DATA_OUT,
    input  M_WR,
    output M_DATA_IN
  );
endinterface

// File: rtl/gpio_debounce_bit.sv
// One-bit debouncer: tracks a candidate level and how many consecutive polls
// agreed with it; the stable level follows once the count reaches
// DEBOUNCE_SAMPLES-1. rise/fall are single-cycle pulses aligned with the
// update strobe, so the stable flop and any event flop change together.
module gpio_debounce_bit #(
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic update,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam logic [2:0] CNT_MAX = 3'(DEBOUNCE_SAMPLES - 1);

  logic       cand_q, cand_d;
  logic [2:0] cnt_q, cnt_d;
  logic       stable_q, stable_d;
  logic       accept;

  // Next candidate/count/stable on an update strobe; hold otherwise.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept   = 1'b0;
    if (update) begin
      if (sample == cand_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 3'd1;
      end else begin
        cand_d = sample;
        cnt_d  = 3'd0;
      end
      if ((cnt_d == CNT_MAX) && (cand_d != stable_q)) begin
        stable_d = cand_d;
        accept   = 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q   <= 1'b0;
      cnt_q    <= 3'd0;
      stable_q <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
  assign rise   = accept & cand_d;
  assign fall   = accept & ~cand_d;
endmodule

// File: rtl/gpio_poll_master.sv
// gpio_poll_master: bus initiator for the gpio peripheral. Forwards host
// writes to the output register, polls the input register every POLL_DIV
// cycles, debounces each input bit and latches edge events behind a
// maskable level interrupt.
// Optional: define GPIO_POLL_FALL_EDGE_EN to let falling stable edges set
// EVENT_PENDING as well; by default only rising edges do.
module gpio_poll_master
  import gpio_poll_pkg::*;
#(
  parameter int BITS             = 16,
  parameter int ADDRESS_BITS     = 4,
  parameter int CLK_FREQ         = 12000000,
  parameter int POLL_DIV         = 1200,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter logic [ADDRESS_BITS-1:0] OUT_ADDR = ADDRESS_BITS'(OUT_ADDR_DEF),
  parameter logic [ADDRESS_BITS-1:0] IN_ADDR  = ADDRESS_BITS'(IN_ADDR_DEF)
) (
  input  logic                     CLK,
  input  logic                     RST,
  gpio_poll_master_if.master       bus,
  input  logic                     HOST_WR_REQ,
  input  logic [GPIO_OUT_BITS-1:0] HOST_WR_DATA,
  output logic                     HOST_WR_ACK,
  input  logic [GPIO_IN_BITS-1:0]  IRQ_MASK,
  input  logic [GPIO_IN_BITS-1:0]  EVENT_CLEAR,
  output logic [GPIO_IN_BITS-1:0]  EVENT_PENDING,
  output logic [GPIO_IN_BITS-1:0]  STABLE_IN,
  output logic                     IRQ
);
  localparam int POLL_CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [POLL_CNT_W-1:0] POLL_LAST = POLL_CNT_W'(POLL_DIV - 1);
  // Clock frequency is informational; the poll interval is given in cycles.
  localparam int unused_clk_freq = CLK_FREQ;

  state_t                    state_q;
  logic [ADDRESS_BITS-1:0]   m_address_q;
  logic [BITS-1:0]           m_data_out_q;
  logic                      m_wr_q;
  logic                      ack_q;
  logic [GPIO_IN_BITS-1:0]   sample_q;

  logic [POLL_CNT_W-1:0]     poll_cnt_q, poll_cnt_d;
  logic                      poll_due_q, poll_due_d;
  logic                      poll_tc;
  logic [GPIO_IN_BITS-1:0]   pending_q, pending_d;
  logic                      irq_q, irq_d;
  logic [GPIO_IN_BITS-1:0]   edge_set;
  logic [GPIO_IN_BITS-1:0]   rise_vec, fall_vec, stable_vec;
  logic                      update_stb;

  // Only the low input bits carry pins; the rest of the read word is ignored.
  logic unused_data_hi;
  assign unused_data_hi = ^bus.M_DATA_IN[BITS-1:GPIO_IN_BITS];

  assign update_stb = (state_q == UPDATE);

  // Free-running poll timer, sticky poll request, event latch and IRQ.
  always_comb begin
    poll_tc    = (poll_cnt_q == POLL_LAST);
    poll_cnt_d = poll_tc ? '0 : poll_cnt_q + POLL_CNT_W'(1);
    // A terminal count while already due is simply absorbed.
    poll_due_d = poll_tc | (poll_due_q & (state_q != READ));
`ifdef GPIO_POLL_FALL_EDGE_EN
    edge_set = rise_vec | fall_vec;
`else
    edge_set = rise_vec;
`endif
    // Set wins over a simultaneous clear.
    pending_d = (pending_q & ~EVENT_CLEAR) | edge_set;
    irq_d     = |(pending_q & IRQ_MASK);
  end

`ifndef GPIO_POLL_FALL_EDGE_EN
  // Falling edges only move STABLE_IN in this build.
  logic unused_fall;
  assign unused_fall = |fall_vec;
`endif

  // Timer and event registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      poll_cnt_q <= '0;
      poll_due_q <= 1'b0;
      pending_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      poll_due_q <= poll_due_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
    end
  end

  // Bus FSM; outputs are registered for the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      m_address_q  <= IN_ADDR;
      m_data_out_q <= '0;
      m_wr_q       <= 1'b0;
      ack_q        <= 1'b0;
      sample_q     <= '0;
    end else begin
      m_address_q <= IN_ADDR;
      m_wr_q      <= 1'b0;
      ack_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (HOST_WR_REQ) begin
            state_q      <= WRITE;
            m_address_q  <= OUT_ADDR;
            m_wr_q       <= 1'b1;
            m_data_out_q <= {{(BITS-GPIO_OUT_BITS){1'b0}}, HOST_WR_DATA};
            ack_q        <= 1'b1;
          end else if (poll_due_q) begin
            state_q <= READ;
          end
        end
        WRITE:  state_q <= IDLE;
        READ: begin
          sample_q <= bus.M_DATA_IN[GPIO_IN_BITS-1:0];
          state_q  <= UPDATE;
        end
        UPDATE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // One debouncer per input pin.
  generate
    for (genvar gi = 0; gi < GPIO_IN_BITS; gi++) begin : g_bit
      gpio_debounce_bit #(
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
      ) u_deb (
        .clk    (CLK),
        .rst    (RST),
        .sample (sample_q[gi]),
        .update (update_stb),
        .stable (stable_vec[gi]),
        .rise   (rise_vec[gi]),
        .fall   (fall_vec[gi])
      );
    end
  endgenerate

  assign bus.M_ADDRESS  = m_address_q;
  assign bus.M_DATA_OUT = m_data_out_q;
  assign bus.M_WR       = m_wr_q;
  assign HOST_WR_ACK    = ack_q;
  assign EVENT_PENDING  = pending_q;
  assign STABLE_IN      = stable_vec;
  assign IRQ            = irq_q;
endmodule

// File: doc/gpio_poll_master.md
Name: gpio_poll_master

Overview:
- Bus initiator that drives the gpio peripheral register interface (ADDRESS / DATA_IN / DATA_OUT / WR) from the master side.
- Forwards host write requests to the gpio output register.
- Polls the gpio input register on a fixed interval and debounces each input bit.
- Latches per-bit edge events and raises a maskable interrupt, so the CPU no longer busy-polls pins.

Parameters:
- BITS, 16, peripheral data bus width
- ADDRESS_BITS, 4, peripheral address width
- CLK_FREQ, 12000000, clock frequency in Hz (documentation only; POLL_DIV is set in cycles)
- POLL_DIV, 1200, cycles between poll reads (100 us at 12 MHz); minimum 4
- DEBOUNCE_SAMPLES, 4, consecutive equal samples needed to accept a bit change; range 1..8
- OUT_ADDR, 4'h0, gpio output register address
- IN_ADDR, 4'h1, gpio input register address

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active high
- M_ADDRESS  out  ADDRESS_BITS  address to peripheral
- M_DATA_OUT  out  BITS  write data to peripheral DATA_IN
- M_DATA_IN  in  BITS  read data from peripheral DATA_OUT (combinational in peripheral)
- M_WR  out  1  write strobe to peripheral
- HOST_WR_REQ  in  1  host requests output-register write
- HOST_WR_DATA  in  4  output pin value
- HOST_WR_ACK  out  1  one-cycle write-accepted pulse
- IRQ_MASK  in  6  per-bit interrupt enable
- EVENT_CLEAR  in  6  per-bit pending clear, one-cycle pulse
- EVENT_PENDING  out  6  latched edge events
- STABLE_IN  out  6  debounced input value
- IRQ  out  1  interrupt, level

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset values:
  - M_ADDRESS=IN_ADDR, M_DATA_OUT=0, M_WR=0, HOST_WR_ACK=0.
  - EVENT_PENDING=0, STABLE_IN=0, IRQ=0.
  - Poll counter, debounce counters and candidates all 0; FSM in IDLE.
- All outputs are registered.
- Poll timer:
  - Counts 0..POLL_DIV-1 continuously.
  - At terminal count it sets poll_due.
  - poll_due stays set until a READ is issued.
  - A further terminal count while poll_due is already set is absorbed; no queueing.
- FSM states: IDLE, WRITE, READ, UPDATE.
- IDLE:
  - If HOST_WR_REQ, go to WRITE. Writes have priority over polls.
  - Else if poll_due, go to READ.
  - Else stay in IDLE.
- WRITE, exactly 1 cycle:
  - M_ADDRESS=OUT_ADDR, M_DATA_OUT={12'h000, HOST_WR_DATA}, M_WR=1, HOST_WR_ACK=1.
  - Next state is IDLE.
- Host write handshake:
  - Host holds HOST_WR_REQ and HOST_WR_DATA stable until the ACK cycle.
  - Host deasserts REQ in the cycle after ACK; a REQ still high then is a new request.
- READ, 1 cycle:
  - M_ADDRESS=IN_ADDR, M_WR=0.
  - M_DATA_IN[5:0] is captured at the end of this cycle into sample; poll_due is cleared.
  - Next state is UPDATE.
- UPDATE, 1 cycle, per bit i:
  - If sample[i]==cand[i]: cnt[i] saturates at DEBOUNCE_SAMPLES-1.
  - Else: cand[i]=sample[i], cnt[i]=0.
  - If cnt[i] (after update) == DEBOUNCE_SAMPLES-1 and cand[i]!=STABLE_IN[i]: STABLE_IN[i]=cand[i] and an edge is flagged.
  - DEBOUNCE_SAMPLES=1 therefore accepts a change on the first differing poll.
  - Next state is IDLE.
- Events:
  - A rising stable edge sets EVENT_PENDING[i].
  - EVENT_CLEAR[i] clears it.
  - Set and clear in the same cycle: set wins.
- IRQ: registered |(EVENT_PENDING & IRQ_MASK); asserts 1 cycle after the pending bit sets.
- Idle bus: M_ADDRESS returns to IN_ADDR, M_WR=0, M_DATA_OUT holds its last value.
- Worst-case poll service latency: 1 write + 1 cycle.
- Reset mid-operation: any in-flight write is aborted with no ACK, and all state is reinitialised; the host re-requests.

Optional Feature:
- Macro: GPIO_POLL_FALL_EDGE_EN.
- Defined: a falling stable edge also sets EVENT_PENDING[i].
- Undefined: only rising edges set events; falling edges update STABLE_IN only.

Decomposition:
- Package gpio_poll_pkg:
  - FSM state enum (IDLE, WRITE, READ, UPDATE).
  - Default OUT_ADDR / IN_ADDR constants.
  - Input width constant GPIO_IN_BITS=6 and output width GPIO_OUT_BITS=4.
- Sub-module gpio_debounce_bit, instantiated 6 times:
  - Holds cand, cnt and stable for one bit.
  - Inputs: sample, update strobe.
  - Outputs: stable, rise, fall pulses.

Test Plan:
- Reset, then idle for POLL_DIV+2 cycles -> M_WR never asserted; one READ cycle with M_ADDRESS=1; STABLE_IN=0, IRQ=0.
- HOST_WR_REQ=1, DATA=4'hA -> next cycle M_ADDRESS=0, M_WR=1, M_DATA_OUT=16'h000A, HOST_WR_ACK=1 for exactly one cycle.
- Poll due and HOST_WR_REQ asserted in the same cycle -> WRITE issues first, READ follows immediately after.
- Input bit 2 driven high continuously, DEBOUNCE_SAMPLES=4, IRQ_MASK=6'h04 -> STABLE_IN[2] rises after the 4th poll; EVENT_PENDING=6'h04; IRQ high one cycle later.
- Input bit 0 glitched high for 2 polls, then low -> STABLE_IN and EVENT_PENDING unchanged.
- EVENT_CLEAR[2] pulsed in the same cycle as a new bit-2 rising edge -> pending stays 1; a clear pulsed alone -> pending 0, IRQ drops next cycle. With GPIO_POLL_FALL_EDGE_EN defined, bit 2 falling -> pending sets.
